// File: rtl/roc_readout_emulator_pkg.sv
// Shared definitions for the ROC readout emulator: trigger command bit
// positions, readout FSM encoding, trigger FIFO entry layout and word builders.
package roc_readout_emulator_pkg;

    // Bit positions on the 5-bit trigger command bus (bit 0 is unused).
    // These must stay in step with the trigger switch encoding.
    localparam int TRG_BIT = 1;
    localparam int RSR_BIT = 2;
    localparam int RST_BIT = 3;
    localparam int CAL_BIT = 4;

    // Fixed prefixes that identify header and hit words on the data bus.
    localparam logic [2:0] HDR_PREFIX = 3'b101;
    localparam logic [3:0] HIT_PREFIX = 4'b0101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DELAY  = 3'd1,
        ST_HEADER = 3'd2,
        ST_HITS   = 3'd3,
        ST_TOUT   = 3'd4
    } state_t;

    // One pending trigger: calibration flag plus the event number it carries.
    typedef struct packed {
        logic       cal;
        logic [7:0] ev;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    function automatic logic [15:0] header_word(input logic empty, input entry_t e);
        return {HDR_PREFIX, empty, 3'b000, e.cal, e.ev};
    endfunction

    function automatic logic [15:0] hit_word(input logic [3:0] k, input logic [7:0] ev);
        return {HIT_PREFIX, k, ev};
    endfunction

endpackage

// File: rtl/roc_readout_emulator_trigger_fifo.sv
// Small synchronous FIFO holding pending trigger entries. A pop and a push in
// the same cycle are both accepted even when full; clear empties it at once.
module roc_readout_emulator_trigger_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sync_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign dout_o  = mem_q[rptr_q];

    assign do_pop  = sync_i && pop_i && !empty_o;
    assign do_push = sync_i && push_i && (!full_o || do_pop);

    // Pointer and occupancy next-state; clear overrides any push or pop.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (sync_i && clear_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage array; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/roc_readout_emulator.sv
// ROC readout emulator: decodes trigger commands into a pending-trigger FIFO
// and answers each token-in with a header, nhits hit words and a token-out.
// All state advances only on cycles with sync=1.
module roc_readout_emulator
    import roc_readout_emulator_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sync,
    input  logic        enable,
    input  logic [4:0]  trg_in,
    input  logic        tin,
    input  logic [7:0]  delay,
    input  logic [3:0]  nhits,
    output logic        tout,
    output logic        data_valid,
    output logic [15:0] data,
    output logic        busy,
    output logic        overflow
);

    logic        cmd_act, cmd_rst, cmd_rsr, cmd_trg, cmd_cal, tin_acc;
    logic        fifo_full, fifo_empty;
    entry_t      fifo_dout, head_entry, push_entry;
    logic        unused_trg0;

    state_t      state_q, state_d;
    logic [7:0]  ev_q, ev_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        cal_armed_q, cal_armed_d;
    logic        ovf_q, ovf_d;
    entry_t      rd_q, rd_d;
    logic        rd_empty_q, rd_empty_d;
    logic [3:0]  hit_q, hit_d;
    logic [3:0]  nh_q, nh_d;
    logic [15:0] data_q, data_d;
    logic        dv_q, dv_d;
    logic        tout_q, tout_d;

    assign unused_trg0 = trg_in[0];

    // Commands are only seen on enabled sync cycles; rst > rsr > trg.
    assign cmd_act = sync && enable;
    assign cmd_rst = cmd_act && trg_in[RST_BIT];
    assign cmd_rsr = cmd_act && trg_in[RSR_BIT] && !cmd_rst;
    assign cmd_trg = cmd_act && trg_in[TRG_BIT] && !cmd_rst && !trg_in[RSR_BIT];
    assign cmd_cal = cmd_act && trg_in[CAL_BIT];
    assign tin_acc = cmd_act && tin && (state_q == ST_IDLE) && !cmd_rst;

    // An empty FIFO reads out as an all-zero entry flagged empty.
    assign head_entry = fifo_empty ? '0 : fifo_dout;
    assign push_entry = {cal_armed_q | cmd_cal, ev_q};

    roc_readout_emulator_trigger_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_trigger_fifo (
        .clk     (clk),
        .reset   (reset),
        .sync_i  (sync),
        .push_i  (cmd_trg),
        .pop_i   (tin_acc),
        .clear_i (cmd_rst || cmd_rsr),
        .din_i   (push_entry),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Event counter, calibration arming and sticky overflow bookkeeping.
    always_comb begin
        ev_d        = ev_q;
        cal_armed_d = cal_armed_q;
        ovf_d       = ovf_q;
        if (cmd_rst) begin
            ev_d        = 8'd0;
            cal_armed_d = 1'b0;
            ovf_d       = 1'b0;
        end
        if (cmd_cal) cal_armed_d = 1'b1;
        if (cmd_trg) begin
            ev_d        = ev_q + 8'd1;
            cal_armed_d = 1'b0;
            // A simultaneous pop frees a slot, so only a pure push on full drops.
            if (fifo_full && !tin_acc) ovf_d = 1'b1;
        end
    end

    // Readout FSM next-state and registered output words.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hit_d      = hit_q;
        nh_d       = nh_q;
        rd_d       = rd_q;
        rd_empty_d = rd_empty_q;
        data_d     = data_q;
        dv_d       = dv_q;
        tout_d     = tout_q;
        if (sync) begin
            dv_d   = 1'b0;
            tout_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tin_acc) begin
                        rd_d       = head_entry;
                        rd_empty_d = fifo_empty;
                        // Zero delay goes straight to the header cycle.
                        if (delay == 8'd0) begin
                            state_d = ST_HEADER;
                            data_d  = header_word(fifo_empty, head_entry);
                            dv_d    = 1'b1;
                        end else begin
                            state_d = ST_DELAY;
                            cnt_d   = delay - 8'd1;
                        end
                    end
                end
                ST_DELAY: begin
                    if (cnt_q == 8'd0) begin
                        state_d = ST_HEADER;
                        data_d  = header_word(rd_empty_q, rd_q);
                        dv_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                ST_HEADER: begin
                    if (nhits == 4'd0 || rd_empty_q) begin
                        state_d = ST_TOUT;
                        tout_d  = 1'b1;
                    end else begin
                        state_d = ST_HITS;
                        nh_d    = nhits;
                        hit_d   = 4'd0;
                        data_d  = hit_word(4'd0, rd_q.ev);
                        dv_d    = 1'b1;
                    end
                end
                ST_HITS: begin
                    if (hit_q == nh_q - 4'd1) begin
                        state_d = ST_TOUT;
                        tout_d  = 1'b1;
                    end else begin
                        hit_d  = hit_q + 4'd1;
                        data_d = hit_word(hit_q + 4'd1, rd_q.ev);
                        dv_d   = 1'b1;
                    end
                end
                ST_TOUT: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
            // rst aborts any readout silently, without a token-out.
            if (cmd_rst) begin
                state_d = ST_IDLE;
                dv_d    = 1'b0;
                tout_d  = 1'b0;
            end
        end
    end

    // State, bookkeeping and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ev_q        <= 8'd0;
            cnt_q       <= 8'd0;
            cal_armed_q <= 1'b0;
            ovf_q       <= 1'b0;
            rd_q        <= '0;
            rd_empty_q  <= 1'b0;
            hit_q       <= 4'd0;
            nh_q        <= 4'd0;
            data_q      <= 16'h0000;
            dv_q        <= 1'b0;
            tout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ev_q        <= ev_d;
            cnt_q       <= cnt_d;
            cal_armed_q <= cal_armed_d;
            ovf_q       <= ovf_d;
            rd_q        <= rd_d;
            rd_empty_q  <= rd_empty_d;
            hit_q       <= hit_d;
            nh_q        <= nh_d;
            data_q      <= data_d;
            dv_q        <= dv_d;
            tout_q      <= tout_d;
        end
    end

    assign tout       = tout_q;
    assign data_valid = dv_q;
    assign data       = data_q;
    assign busy       = (state_q != ST_IDLE);
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_roc_readout_emulator.sv
// Bench for roc_readout_emulator: directed trigger/token sequences, a schedule
// based model of expected outputs per sync cycle, and literal word checks.
module tb_roc_readout_emulator;

    localparam int FIFO_DEPTH = 4;
    localparam int SCH_N = 4096;
    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_TRG  = 5'b00010;
    localparam logic [4:0] C_RSR  = 5'b00100;
    localparam logic [4:0] C_RST  = 5'b01000;
    localparam logic [4:0] C_CAL  = 5'b10000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sync = 1'b0;
    logic        enable = 1'b1;
    logic [4:0]  trg_in = 5'd0;
    logic        tin = 1'b0;
    logic [7:0]  delay = 8'd0;
    logic [3:0]  nhits = 4'd0;
    logic        tout, data_valid, busy, overflow;
    logic [15:0] data;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 0;
    bit sync_toggle = 0;

    // Model state: expected outputs indexed by sync-edge number.
    logic        sch_dv   [SCH_N];
    logic        sch_tout [SCH_N];
    logic        sch_busy [SCH_N];
    logic [15:0] sch_data [SCH_N];
    logic [8:0]  m_fifo [$];
    logic [7:0]  m_ev = 8'd0;
    logic        m_cal = 1'b0;
    logic        m_ovf = 1'b0;
    int          m_s = 0;
    int          m_busy_end = -1;

    roc_readout_emulator #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .sync       (sync),
        .enable     (enable),
        .trg_in     (trg_in),
        .tin        (tin),
        .delay      (delay),
        .nhits      (nhits),
        .tout       (tout),
        .data_valid (data_valid),
        .data       (data),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Apply the rules for one sync edge: token first, then rst > rsr > trg, cal.
    task automatic model_edge(input logic [4:0] tv, input logic tinv);
        logic [4:0] c;
        logic [8:0] ent;
        logic [3:0] kk;
        logic       emp;
        int n, d, t;
        m_s++;
        c = enable ? tv : 5'd0;
        if (enable && tinv && (m_s - 1 > m_busy_end) && !c[3]) begin
            emp = (m_fifo.size() == 0);
            ent = emp ? 9'd0 : m_fifo.pop_front();
            n = emp ? 0 : int'(nhits);
            d = int'(delay);
            t = m_s;
            sch_dv[t + d]   = 1'b1;
            sch_data[t + d] = {3'b101, emp, 3'b000, ent[8], ent[7:0]};
            for (int k = 0; k < n; k++) begin
                kk = 4'(k);
                sch_dv[t + d + 1 + k]   = 1'b1;
                sch_data[t + d + 1 + k] = {4'b0101, kk, ent[7:0]};
            end
            sch_tout[t + d + n + 1] = 1'b1;
            for (int i = t; i <= t + d + n + 1; i++) sch_busy[i] = 1'b1;
            m_busy_end = t + d + n + 1;
        end
        if (c[3]) begin
            m_fifo.delete();
            m_ev  = 8'd0;
            m_cal = 1'b0;
            m_ovf = 1'b0;
            for (int i = m_s; i <= m_busy_end; i++) begin
                sch_dv[i] = 1'b0; sch_tout[i] = 1'b0; sch_busy[i] = 1'b0;
            end
            m_busy_end = m_s - 1;
        end else if (c[2]) begin
            m_fifo.delete();
        end
        if (c[4]) m_cal = 1'b1;
        if (c[1] && !c[2] && !c[3]) begin
            if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back({m_cal, m_ev});
            else m_ovf = 1'b1;
            m_ev  = m_ev + 8'd1;
            m_cal = 1'b0;
        end
    endtask

    // One sync cycle; in toggle mode preceded by a non-sync cycle with junk inputs.
    task automatic cyc(input logic [4:0] tv, input logic tinv);
        if (sync_toggle) begin
            sync = 1'b0; trg_in = C_TRG; tin = 1'b1;
            @(posedge clk); #1;
        end
        sync = 1'b1; trg_in = tv; tin = tinv;
        @(posedge clk);
        model_edge(tv, tinv);
        #1;
        trg_in = C_NONE; tin = 1'b0;
    endtask

    // Token-in, then literal checks on header, each hit word and the token-out.
    task automatic do_readout(input logic [15:0] hdr, input int n, input logic [4:0] tv);
        logic [3:0]  kk;
        logic [15:0] w;
        cyc(tv, 1'b1);
        for (int i = 0; i < int'(delay); i++) cyc(C_NONE, 1'b0);
        check("header", data, hdr);
        check("header_valid", {15'd0, data_valid}, 16'd1);
        for (int k = 0; k < n; k++) begin
            cyc(C_NONE, 1'b0);
            kk = 4'(k);
            w  = {4'h5, kk, hdr[7:0]};
            check("hit", data, w);
        end
        cyc(C_NONE, 1'b0);
        check("tout", {15'd0, tout}, 16'd1);
        cyc(C_NONE, 1'b0);
        check("idle_after_tout", {15'd0, busy}, 16'd0);
    endtask

    // Compare DUT against the model on every clock once out of reset.
    always @(negedge clk) begin
        if (chk_on) begin
            check("m_tout", {15'd0, tout}, {15'd0, sch_tout[m_s]});
            check("m_valid", {15'd0, data_valid}, {15'd0, sch_dv[m_s]});
            check("m_busy", {15'd0, busy}, {15'd0, sch_busy[m_s]});
            check("m_overflow", {15'd0, overflow}, {15'd0, m_ovf});
            if (sch_dv[m_s]) check("m_data", data, sch_data[m_s]);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < SCH_N; i++) begin
            sch_dv[i] = 1'b0; sch_tout[i] = 1'b0; sch_busy[i] = 1'b0; sch_data[i] = 16'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_tout", {15'd0, tout}, 16'd0);
        check("rst_valid", {15'd0, data_valid}, 16'd0);
        check("rst_data", data, 16'h0000);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_overflow", {15'd0, overflow}, 16'd0);
        reset = 1'b0;
        chk_on = 1;

        // Basic readout: delay 3, two hits.
        delay = 8'd3; nhits = 4'd2;
        cyc(C_TRG, 1'b0);
        do_readout(16'hA000, 2, C_NONE);

        // Empty FIFO, zero delay: header then token-out, no hits.
        delay = 8'd0;
        do_readout(16'hB000, 0, C_NONE);

        // Exactly full is not overflow; rsr clears; cal marks next trigger only.
        repeat (4) cyc(C_TRG, 1'b0);
        check("full_no_overflow", {15'd0, overflow}, 16'd0);
        cyc(C_RSR, 1'b0);
        cyc(C_CAL, 1'b0);
        cyc(C_TRG, 1'b0);
        cyc(C_TRG, 1'b0);
        delay = 8'd1; nhits = 4'd0;
        do_readout(16'hA105, 0, C_NONE);
        do_readout(16'hA006, 0, C_NONE);

        // Overflow on the fifth trigger, drain, then rst clears overflow and ev.
        cyc(C_RST, 1'b0);
        delay = 8'd2; nhits = 4'd1;
        repeat (5) cyc(C_TRG, 1'b0);
        check("overflow_set", {15'd0, overflow}, 16'd1);
        do_readout(16'hA000, 1, C_NONE);
        do_readout(16'hA001, 1, C_NONE);
        do_readout(16'hA002, 1, C_NONE);
        do_readout(16'hA003, 1, C_NONE);
        do_readout(16'hB000, 0, C_NONE);
        check("overflow_sticky", {15'd0, overflow}, 16'd1);
        cyc(C_RST, 1'b0);
        check("overflow_cleared", {15'd0, overflow}, 16'd0);
        cyc(C_TRG, 1'b0);
        do_readout(16'hA000, 1, C_NONE);

        // rst during hit words aborts without token-out.
        cyc(C_RST, 1'b0);
        delay = 8'd0; nhits = 4'd3;
        cyc(C_TRG, 1'b0);
        cyc(C_NONE, 1'b1);
        check("abort_header", data, 16'hA000);
        cyc(C_NONE, 1'b0);
        check("abort_hit0", data, 16'h5000);
        cyc(C_RST, 1'b0);
        check("abort_busy", {15'd0, busy}, 16'd0);
        check("abort_no_tout", {15'd0, tout}, 16'd0);
        cyc(C_NONE, 1'b0);
        cyc(C_TRG, 1'b0);
        do_readout(16'hA000, 3, C_NONE);

        // trg together with tin: pop the old entry first, no bypass.
        nhits = 4'd0;
        cyc(C_TRG, 1'b0);
        do_readout(16'hA001, 0, C_TRG);
        do_readout(16'hA002, 0, C_NONE);
        do_readout(16'hB000, 0, C_TRG);
        do_readout(16'hA003, 0, C_NONE);

        // Pop and push on a full FIFO: accepted without overflow.
        cyc(C_RST, 1'b0);
        repeat (4) cyc(C_TRG, 1'b0);
        do_readout(16'hA000, 0, C_TRG);
        check("full_popush_no_ovf", {15'd0, overflow}, 16'd0);
        do_readout(16'hA001, 0, C_NONE);
        do_readout(16'hA002, 0, C_NONE);
        do_readout(16'hA003, 0, C_NONE);
        do_readout(16'hA004, 0, C_NONE);

        // enable=0 mid-readout: readout completes, new trg/tin ignored.
        cyc(C_RST, 1'b0);
        cyc(C_TRG, 1'b0);
        delay = 8'd1; nhits = 4'd1;
        cyc(C_NONE, 1'b1);
        enable = 1'b0;
        cyc(C_TRG, 1'b0);
        check("dis_header", data, 16'hA000);
        cyc(C_TRG, 1'b1);
        check("dis_hit", data, 16'h5000);
        cyc(C_NONE, 1'b0);
        check("dis_tout", {15'd0, tout}, 16'd1);
        cyc(C_NONE, 1'b1);
        cyc(C_TRG, 1'b1);
        check("dis_tin_ignored", {15'd0, busy}, 16'd0);
        enable = 1'b1;
        do_readout(16'hB000, 0, C_NONE);

        // Event counter wraps 255 -> 0.
        cyc(C_RST, 1'b0);
        delay = 8'd0; nhits = 4'd0;
        repeat (255) cyc(C_TRG, 1'b0);
        cyc(C_RSR, 1'b0);
        cyc(C_TRG, 1'b0);
        cyc(C_TRG, 1'b0);
        do_readout(16'hA0FF, 0, C_NONE);
        do_readout(16'hA000, 0, C_NONE);

        // Same basic readout with sync every other clock.
        sync_toggle = 1;
        cyc(C_RST, 1'b0);
        delay = 8'd3; nhits = 4'd2;
        cyc(C_TRG, 1'b0);
        do_readout(16'hA000, 2, C_NONE);
        cyc(C_TRG, 1'b0);
        do_readout(16'hA001, 2, C_NONE);
        sync_toggle = 0;
        cyc(C_NONE, 1'b0);

        chk_on = 0;
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
